// File: rtl/rx_iq_packer_if.sv
// Byte-stream handshake between the I/Q packer and the downstream packet builder.
interface rx_iq_packer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_first;
   logic       out_last;

   modport master (output out_data, out_valid, out_first, out_last, input out_ready);
   modport slave  (input out_data, out_valid, out_first, out_last, output out_ready);
endinterface

// File: rtl/rx_iq_packer.sv
// Buffers 24-bit I/Q pairs from the receiver and serialises them MSB-first as a
// six-byte-per-pair stream with frame markers and a sticky sample-loss flag.
module rx_iq_packer #(
   parameter int FIFO_DEPTH        = 16,
   parameter int SAMPLES_PER_FRAME = 63
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              in_strobe,
   input  logic [23:0]                       in_I,
   input  logic [23:0]                       in_Q,
   rx_iq_packer_if.master                    out,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              overflow,
   input  logic                              clear_overflow
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FW = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
   localparam logic [CW-1:0] FULL       = CW'(FIFO_DEPTH);
   localparam logic [FW-1:0] FRAME_LAST = FW'(SAMPLES_PER_FRAME - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t        state_r;
   logic [47:0]   mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [39:0]   shift_r;
   logic [2:0]    idx_r;
   logic [FW-1:0] frame_r;
   logic [7:0]    data_r;
   logic          valid_r;
   logic          first_r;
   logic          last_r;
   logic          ovf_r;

   logic          accept_s;
   logic          pair_done_s;
   logic          push_s;
   logic          drop_s;
   logic          pop_s;
   logic [FW-1:0] frame_next_s;
   logic [47:0]   head_s;

   // Handshake decode; full/empty decisions use the count held before this edge.
   always_comb begin
      accept_s    = valid_r & out.out_ready;
      pair_done_s = accept_s & (idx_r == 3'd5);
      push_s      = in_strobe & (count_r != FULL);
      drop_s      = in_strobe & (count_r == FULL);
      head_s      = mem_r[rd_ptr_r];
      if (state_r == IDLE) begin
         pop_s = (count_r != '0);
      end else begin
         pop_s = pair_done_s & (count_r != '0);
      end
      if (frame_r == FRAME_LAST) begin
         frame_next_s = '0;
      end else begin
         frame_next_s = frame_r + FW'(1);
      end
   end

   // Pair storage; contents need no reset because the pointers gate every read.
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {in_I, in_Q};
      end
   end

   // FIFO pointers, occupancy and sticky overflow (a drop wins over a clear).
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         ovf_r    <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (clear_overflow) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Serialiser FSM; all stream outputs are registered and only move on acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
         shift_r <= '0;
         idx_r   <= 3'd0;
         frame_r <= '0;
         data_r  <= 8'h00;
         valid_r <= 1'b0;
         first_r <= 1'b0;
         last_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  state_r <= SEND;
                  shift_r <= head_s[39:0];
                  data_r  <= head_s[47:40];
                  idx_r   <= 3'd0;
                  valid_r <= 1'b1;
                  first_r <= (frame_r == '0);
                  last_r  <= 1'b0;
               end
            end
            SEND: begin
               if (accept_s) begin
                  if (idx_r != 3'd5) begin
                     idx_r   <= idx_r + 3'd1;
                     data_r  <= shift_r[39:32];
                     shift_r <= {shift_r[31:0], 8'h00};
                     first_r <= 1'b0;
                     last_r  <= (idx_r == 3'd4) & (frame_r == FRAME_LAST);
                  end else begin
                     frame_r <= frame_next_s;
                     if (pop_s) begin
                        shift_r <= head_s[39:0];
                        data_r  <= head_s[47:40];
                        idx_r   <= 3'd0;
                        first_r <= (frame_next_s == '0);
                        last_r  <= 1'b0;
                     end else begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        first_r <= 1'b0;
                        last_r  <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign out.out_data  = data_r;
   assign out.out_valid = valid_r;
   assign out.out_first = first_r;
   assign out.out_last  = last_r;
   assign fifo_count    = count_r;
   assign overflow      = ovf_r;
endmodule
